// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the pipeline stall/flush sequencer.
//   ctrl_state_t    : sequencer state (RUN, DMEM_WAIT, MDU_BUSY, DRAIN, HALT)
//   PERF_CNT_W      : width of the performance counters
//   MDU_CYCLES_MAX  : largest legal MUL/DIV occupancy in EX
//   CNT_W           : width of the shared MDU/drain down-counter
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        DMEM_WAIT = 3'd1,
        MDU_BUSY  = 3'd2,
        DRAIN     = 3'd3,
        HALT      = 3'd4
    } ctrl_state_t;

    localparam int PERF_CNT_W     = 32;
    localparam int MDU_CYCLES_MAX = 16;
    // Covers MDU_CYCLES-2 (<= 14) and DRAIN_CYCLES-1 for drains up to 256.
    localparam int CNT_W          = 8;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Groups the hazard inputs and the per-stage control outputs of pipeline_ctrl.
//   slave  : the sequencer (consumes hazards, drives stall/bubble/flush)
//   master : the pipeline datapath / hazard_detector side
// Data-memory handshake: dmem_req_mem is the request (valid) from MEM and
// dmem_ready the memory's ready; an access completes in the cycle where both
// are high. While dmem_req_mem=1 and dmem_ready=0 the requester holds its
// request stable, and the sequencer freezes every stage up to MEM.
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic                  load_hazard;
    logic                  branch_taken_ex;
    logic                  mdu_op_ex;
    logic                  halt_req_ex;
    logic                  dmem_req_mem;
    logic                  dmem_ready;

    logic                  stall_if;
    logic                  stall_id;
    logic                  stall_ex;
    logic                  stall_mem;
    logic                  bubble_ex;
    logic                  bubble_mem;
    logic                  bubble_wb;
    logic                  flush_id;
    logic                  pc_redirect;
    logic                  mdu_start;
    logic                  mdu_result_vld;
    logic                  halted;
    logic [PERF_CNT_W-1:0] perf_stall_cnt;
    logic [PERF_CNT_W-1:0] perf_flush_cnt;

    modport master (
        output load_hazard, branch_taken_ex, mdu_op_ex, halt_req_ex,
               dmem_req_mem, dmem_ready,
        input  stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem,
               bubble_wb, flush_id, pc_redirect, mdu_start, mdu_result_vld,
               halted, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  load_hazard, branch_taken_ex, mdu_op_ex, halt_req_ex,
               dmem_req_mem, dmem_ready,
        output stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_mem,
               bubble_wb, flush_id, pc_redirect, mdu_start, mdu_result_vld,
               halted, perf_stall_cnt, perf_flush_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_perf_counters.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_perf_counters
// Two free-running wrap-around event counters, cleared by reset.
//   clk, rst     : clock, synchronous active-high reset
//   stall_i      : count this cycle as a front-end stall cycle
//   flush_i      : count this cycle as an ID flush cycle
//   stall_cnt_o  : number of stall cycles since reset (wraps)
//   flush_cnt_o  : number of flush cycles since reset (wraps)
// Only instantiated when PIPELINE_CTRL_PERF_EN is defined.
// -----------------------------------------------------------------------------
module pipeline_ctrl_perf_counters
    import pipeline_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic [PERF_CNT_W-1:0] stall_cnt_o,
    output logic [PERF_CNT_W-1:0] flush_cnt_o
);

    logic [PERF_CNT_W-1:0] stall_cnt_q;
    logic [PERF_CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_i) stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
            if (flush_i) flush_cnt_q <= flush_cnt_q + PERF_CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Merges load-use hazards,
// EX branch redirects, data-memory waits, multi-cycle MUL/DIV occupancy and
// halt requests into per-stage stall/bubble/flush controls.
//   clk, rst  : clock, synchronous active-high reset
//   ctl       : pipeline_ctrl_if.slave (hazard inputs, stage controls, perf)
//   state_o   : current sequencer state, for observation
// Parameters:
//   MDU_CYCLES   : cycles a MUL/DIV occupies EX (2..MDU_CYCLES_MAX)
//   DRAIN_CYCLES : cycles MEM/WB get to retire before halted rises (>= 1)
// Build option: define PIPELINE_CTRL_PERF_EN to include the stall/flush
// performance counters; otherwise both counter outputs read 0.
// Controls are combinational from state and inputs so a hazard stalls the
// pipe in the same cycle it is seen.
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES   = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave ctl,
    output ctrl_state_t    state_o
);

    if (MDU_CYCLES < 2 || MDU_CYCLES > MDU_CYCLES_MAX) begin : g_bad_mdu_cycles
        $error("pipeline_ctrl: MDU_CYCLES out of range");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > (1 << CNT_W)) begin : g_bad_drain_cycles
        $error("pipeline_ctrl: DRAIN_CYCLES out of range");
    end

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_dec;

    logic stall_if, stall_id, stall_ex, stall_mem;
    logic bubble_ex, bubble_mem, bubble_wb, flush_id;
    logic pc_redirect, mdu_start, mdu_result_vld, halted;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        run_dec        = 1'b0;
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        stall_ex       = 1'b0;
        stall_mem      = 1'b0;
        bubble_ex      = 1'b0;
        bubble_mem     = 1'b0;
        bubble_wb      = 1'b0;
        flush_id       = 1'b0;
        pc_redirect    = 1'b0;
        mdu_start      = 1'b0;
        mdu_result_vld = 1'b0;
        halted         = 1'b0;

        if (rst) begin
            // Keep ID/EX/MEM empty while the core is held in reset.
            flush_id   = 1'b1;
            bubble_ex  = 1'b1;
            bubble_mem = 1'b1;
        end else begin
            case (state_q)
                RUN: run_dec = 1'b1;
                DMEM_WAIT: begin
                    // The ready cycle releases the pipe and is decoded like RUN,
                    // so a redirect/halt held by the frozen EX takes effect now.
                    if (ctl.dmem_ready) begin
                        run_dec = 1'b1;
                    end else begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        stall_mem = 1'b1;
                        bubble_wb = 1'b1;
                    end
                end
                MDU_BUSY: begin
                    if (cnt_q != '0) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                        cnt_d      = cnt_q - CNT_W'(1);
                    end else begin
                        mdu_result_vld = 1'b1;
                        state_d        = RUN;
                    end
                end
                DRAIN: begin
                    stall_if  = 1'b1;
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                    else             state_d = HALT;
                end
                HALT: begin
                    halted    = 1'b1;
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
                default: state_d = RUN;
            endcase

            if (run_dec) begin
                state_d = RUN;
                if (ctl.dmem_req_mem && !ctl.dmem_ready) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    stall_mem = 1'b1;
                    bubble_wb = 1'b1;
                    state_d   = DMEM_WAIT;
                end else if (ctl.mdu_op_ex) begin
                    // First of MDU_CYCLES EX cycles; the counter covers the
                    // remaining stall cycles before the result cycle.
                    mdu_start  = 1'b1;
                    stall_if   = 1'b1;
                    stall_id   = 1'b1;
                    stall_ex   = 1'b1;
                    bubble_mem = 1'b1;
                    cnt_d      = CNT_W'(MDU_CYCLES - 2);
                    state_d    = MDU_BUSY;
                end else if (ctl.halt_req_ex) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                    stall_if  = 1'b1;
                    cnt_d     = CNT_W'(DRAIN_CYCLES - 1);
                    state_d   = DRAIN;
                end else if (ctl.branch_taken_ex) begin
                    // The ID instruction is killed, so a load-use hazard on it
                    // is irrelevant.
                    pc_redirect = 1'b1;
                    flush_id    = 1'b1;
                    bubble_ex   = 1'b1;
                end else if (ctl.load_hazard) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    a_ex_ops_exclusive: assert property (@(posedge clk) disable iff (rst)
        $onehot0({ctl.mdu_op_ex, ctl.branch_taken_ex, ctl.halt_req_ex}));

    assign ctl.stall_if       = stall_if;
    assign ctl.stall_id       = stall_id;
    assign ctl.stall_ex       = stall_ex;
    assign ctl.stall_mem      = stall_mem;
    assign ctl.bubble_ex      = bubble_ex;
    assign ctl.bubble_mem     = bubble_mem;
    assign ctl.bubble_wb      = bubble_wb;
    assign ctl.flush_id       = flush_id;
    assign ctl.pc_redirect    = pc_redirect;
    assign ctl.mdu_start      = mdu_start;
    assign ctl.mdu_result_vld = mdu_result_vld;
    assign ctl.halted         = halted;
    assign state_o            = state_q;

`ifdef PIPELINE_CTRL_PERF_EN
    pipeline_ctrl_perf_counters u_perf (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_if),
        .flush_i     (flush_id),
        .stall_cnt_o (ctl.perf_stall_cnt),
        .flush_cnt_o (ctl.perf_flush_cnt)
    );
`else
    assign ctl.perf_stall_cnt = '0;
    assign ctl.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed and randomized scenarios for pipeline_ctrl. Each cycle's expected
// control vector comes from a per-scenario table of the documented control
// patterns; expected perf counts are accumulated from those expected vectors.
// Vector bit order: {stall_if, stall_id, stall_ex, stall_mem, bubble_ex,
// bubble_mem, bubble_wb, flush_id, pc_redirect, mdu_start, mdu_result_vld,
// halted}.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int MDU_CYCLES   = 4;
    localparam int DRAIN_CYCLES = 2;

    localparam logic [11:0] V_IDLE       = 12'b0000_0000_0000;
    localparam logic [11:0] V_RESET      = 12'b0000_1101_0000;
    localparam logic [11:0] V_LOADUSE    = 12'b1100_1000_0000;
    localparam logic [11:0] V_BRANCH     = 12'b0000_1001_1000;
    localparam logic [11:0] V_DMEM       = 12'b1111_0010_0000;
    localparam logic [11:0] V_MDU_START  = 12'b1110_0100_0100;
    localparam logic [11:0] V_MDU_STALL  = 12'b1110_0100_0000;
    localparam logic [11:0] V_MDU_DONE   = 12'b0000_0000_0010;
    localparam logic [11:0] V_HALT_FLUSH = 12'b1000_1001_0000;
    localparam logic [11:0] V_HALTED     = 12'b1100_1000_0001;

    logic        clk = 1'b0;
    logic        rst;
    ctrl_state_t state_o;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_stall_cnt = '0;
    logic [31:0] exp_flush_cnt = '0;
    int          sel;

    pipeline_ctrl_if pif ();

    pipeline_ctrl #(
        .MDU_CYCLES   (MDU_CYCLES),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctl     (pif.slave),
        .state_o (state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- helpers / driver tasks ----------------
    function automatic logic [11:0] obs_vec();
        return {pif.stall_if, pif.stall_id, pif.stall_ex, pif.stall_mem,
                pif.bubble_ex, pif.bubble_mem, pif.bubble_wb, pif.flush_id,
                pif.pc_redirect, pif.mdu_start, pif.mdu_result_vld, pif.halted};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        pif.load_hazard     = 1'b0;
        pif.branch_taken_ex = 1'b0;
        pif.mdu_op_ex       = 1'b0;
        pif.halt_req_ex     = 1'b0;
        pif.dmem_req_mem    = 1'b0;
        pif.dmem_ready      = 1'b0;
    endtask

    // One clock cycle: compare controls and perf counters at the falling
    // edge, then advance the perf model and step past the rising edge.
    task automatic cyc(input string tag, input logic [11:0] exp);
        logic [31:0] es, ef;
        @(negedge clk);
        check(tag, 32'(obs_vec()), 32'(exp));
`ifdef PIPELINE_CTRL_PERF_EN
        es = exp_stall_cnt;
        ef = exp_flush_cnt;
`else
        es = '0;
        ef = '0;
`endif
        if (!rst) begin
            check({tag, "_perf_stall"}, pif.perf_stall_cnt, es);
            check({tag, "_perf_flush"}, pif.perf_flush_cnt, ef);
        end
        if (rst) begin
            exp_stall_cnt = '0;
            exp_flush_cnt = '0;
        end else begin
            exp_stall_cnt = exp_stall_cnt + 32'(exp[11]);
            exp_flush_cnt = exp_flush_cnt + 32'(exp[4]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input ctrl_state_t exp);
        check(tag, 32'(state_o), 32'(exp));
    endtask

    // Remaining MUL/DIV cycles after the start cycle: MDU_CYCLES-2 stalls,
    // then the result cycle. Load hazards during occupancy are ignored.
    task automatic mdu_tail(input string tag, input bit noise);
        for (int i = 0; i < MDU_CYCLES - 2; i++) begin
            pif.load_hazard = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            cyc({tag, "_stall"}, V_MDU_STALL);
        end
        pif.load_hazard = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc({tag, "_done"}, V_MDU_DONE);
        pif.mdu_op_ex   = 1'b0;
        pif.load_hazard = 1'b0;
    endtask

    task automatic run_mdu(input string tag, input bit noise);
        pif.mdu_op_ex   = 1'b1;
        pif.load_hazard = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        cyc({tag, "_start"}, V_MDU_START);
        mdu_tail(tag, noise);
        check_state({tag, "_state"}, RUN);
    endtask

    // Data-memory wait of w cycles. follow: 0 nothing, 1 taken branch held
    // in EX, 2 MUL/DIV held in EX; it acts on the ready cycle.
    task automatic run_dmem(input string tag, input int w, input int follow);
        pif.dmem_req_mem    = 1'b1;
        pif.dmem_ready      = 1'b0;
        pif.branch_taken_ex = (follow == 1);
        pif.mdu_op_ex       = (follow == 2);
        for (int i = 0; i < w; i++) begin
            pif.load_hazard = 1'($urandom_range(0, 1));
            cyc({tag, "_wait"}, V_DMEM);
            if (i == 0) check_state({tag, "_state_wait"}, DMEM_WAIT);
        end
        pif.load_hazard = 1'b0;
        pif.dmem_ready  = 1'b1;
        if (follow == 1) begin
            cyc({tag, "_ready_br"}, V_BRANCH);
            clear_inputs();
            cyc({tag, "_after_br"}, V_IDLE);
        end else if (follow == 2) begin
            cyc({tag, "_ready_mdu"}, V_MDU_START);
            pif.dmem_req_mem = 1'b0;
            pif.dmem_ready   = 1'b0;
            mdu_tail(tag, 1'b0);
        end else begin
            cyc({tag, "_ready"}, V_IDLE);
        end
        clear_inputs();
        check_state({tag, "_state_end"}, RUN);
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        clear_inputs();
        rst = 1'b1;
        cyc("reset0", V_RESET);
        cyc("reset1", V_RESET);
        rst = 1'b0;
        check_state("state_after_reset", RUN);
        cyc("idle", V_IDLE);

        pif.load_hazard = 1'b1;
        cyc("loaduse", V_LOADUSE);
        pif.load_hazard = 1'b0;
        check_state("loaduse_state", RUN);
        cyc("loaduse_after", V_IDLE);

        run_mdu("mdu", 1'b0);

        run_dmem("dmem5", 5, 0);

        pif.branch_taken_ex = 1'b1;
        pif.load_hazard     = 1'b1;
        cyc("branch_loaduse", V_BRANCH);
        clear_inputs();

        run_dmem("dmem_branch", 3, 1);
        run_dmem("dmem_mdu", 2, 2);

        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0: cyc("rnd_idle", V_IDLE);
                1: begin
                    pif.load_hazard = 1'b1;
                    cyc("rnd_loaduse", V_LOADUSE);
                    pif.load_hazard = 1'b0;
                end
                2: begin
                    pif.branch_taken_ex = 1'b1;
                    pif.load_hazard     = 1'($urandom_range(0, 1));
                    cyc("rnd_branch", V_BRANCH);
                    clear_inputs();
                end
                3: run_mdu("rnd_mdu", 1'b1);
                default: run_dmem("rnd_dmem", int'($urandom_range(1, 6)),
                                  int'($urandom_range(0, 2)));
            endcase
        end

        // Reset in the middle of a MUL/DIV: no result pulse afterwards.
        pif.mdu_op_ex = 1'b1;
        cyc("rstmdu_start", V_MDU_START);
        cyc("rstmdu_stall", V_MDU_STALL);
        rst           = 1'b1;
        pif.mdu_op_ex = 1'b0;
        cyc("rstmdu_rst", V_RESET);
        rst = 1'b0;
        check_state("rstmdu_state", RUN);
        cyc("rstmdu_after", V_IDLE);

        // Reset in the middle of a data-memory wait.
        pif.dmem_req_mem = 1'b1;
        cyc("rstdmem_wait", V_DMEM);
        rst = 1'b1;
        clear_inputs();
        cyc("rstdmem_rst", V_RESET);
        rst = 1'b0;
        cyc("rstdmem_after", V_IDLE);

        // Halt held behind a data-memory wait, then drain and halt.
        pif.dmem_req_mem = 1'b1;
        pif.halt_req_ex  = 1'b1;
        cyc("halt_dmem_wait", V_DMEM);
        pif.dmem_ready = 1'b1;
        cyc("halt_req", V_HALT_FLUSH);
        clear_inputs();
        for (int i = 0; i < DRAIN_CYCLES; i++) cyc("halt_drain", V_HALT_FLUSH);
        for (int i = 0; i < 3; i++) begin
            pif.branch_taken_ex = 1'($urandom_range(0, 1));
            pif.load_hazard     = 1'($urandom_range(0, 1));
            cyc("halted", V_HALTED);
        end
        check_state("halt_state", HALT);
        clear_inputs();

        rst = 1'b1;
        cyc("halt_rst", V_RESET);
        rst = 1'b0;
        cyc("halt_rst_after", V_IDLE);
        check_state("final_state", RUN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
